// File: rtl/complex_mac_pipe.sv
// Four-stage pipelined complex multiplier with per-beat conjugation and an
// optional saturating dot-product accumulator at the output stage.
module complex_mac_pipe #(
    parameter int W     = 16,
    parameter int ACC_W = 40,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ce,
    input  logic                 in_valid,
    input  logic                 in_last,
    input  logic                 acc_en,
    input  logic [1:0]           mode,
    input  logic [2*W-1:0]       a,
    input  logic [2*W-1:0]       b,
    output logic                 out_valid,
    output logic [2*ACC_W-1:0]   result,
    output logic                 ovf,
    output logic [CNT_W-1:0]     beat_cnt
);
    typedef enum logic {IDLE = 1'b0, ACCUM = 1'b1} state_t;

    genvar gi;

    logic           s1_valid_q, s1_last_q, s1_acc_en_q;
    logic [1:0]     s1_mode_q;
    logic [2*W-1:0] s1_a_q, s1_b_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            s1_acc_en_q <= 1'b0;
            s1_mode_q   <= 2'b00;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
        end else if (ce) begin
            s1_valid_q  <= in_valid;
            s1_last_q   <= in_last;
            s1_acc_en_q <= acc_en;
            s1_mode_q   <= mode;
            s1_a_q      <= a;
            s1_b_q      <= b;
        end
    end

    // Operands widened to 2W so the low 2W bits of each product are exact.
    logic [2*W-1:0] ar_x, ai_x, br_x, bi_x;
    assign ar_x = {{W{s1_a_q[2*W-1]}}, s1_a_q[2*W-1:W]};
    assign ai_x = {{W{s1_a_q[W-1]}},   s1_a_q[W-1:0]};
    assign br_x = {{W{s1_b_q[2*W-1]}}, s1_b_q[2*W-1:W]};
    assign bi_x = {{W{s1_b_q[W-1]}},   s1_b_q[W-1:0]};

    logic           s2_valid_q, s2_last_q, s2_acc_en_q;
    logic [1:0]     s2_mode_q;
    logic [2*W-1:0] s2_rr_q, s2_ii_q, s2_ri_q, s2_ir_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q  <= 1'b0;
            s2_last_q   <= 1'b0;
            s2_acc_en_q <= 1'b0;
            s2_mode_q   <= 2'b00;
            s2_rr_q     <= '0;
            s2_ii_q     <= '0;
            s2_ri_q     <= '0;
            s2_ir_q     <= '0;
        end else if (ce) begin
            s2_valid_q  <= s1_valid_q;
            s2_last_q   <= s1_last_q;
            s2_acc_en_q <= s1_acc_en_q;
            s2_mode_q   <= s1_mode_q;
            s2_rr_q     <= ar_x * br_x;
            s2_ii_q     <= ai_x * bi_x;
            s2_ri_q     <= ar_x * bi_x;
            s2_ir_q     <= ai_x * br_x;
        end
    end

    // Conjugation is a choice of add/subtract on the products, never an input negation.
    logic [ACC_W-1:0] rr_e, ii_e, ri_e, ir_e, re_d, im_d;
    assign rr_e = {{(ACC_W-2*W){s2_rr_q[2*W-1]}}, s2_rr_q};
    assign ii_e = {{(ACC_W-2*W){s2_ii_q[2*W-1]}}, s2_ii_q};
    assign ri_e = {{(ACC_W-2*W){s2_ri_q[2*W-1]}}, s2_ri_q};
    assign ir_e = {{(ACC_W-2*W){s2_ir_q[2*W-1]}}, s2_ir_q};

    always_comb begin
        re_d = rr_e - ii_e;
        im_d = ri_e + ir_e;
        case (s2_mode_q)
            2'b01: begin
                re_d = rr_e + ii_e;
                im_d = ri_e - ir_e;
            end
            2'b10: begin
                re_d = rr_e + ii_e;
                im_d = ir_e - ri_e;
            end
            default: ;
        endcase
    end

    logic             s3_valid_q, s3_last_q, s3_acc_en_q;
    logic [ACC_W-1:0] s3_q [2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s3_valid_q  <= 1'b0;
            s3_last_q   <= 1'b0;
            s3_acc_en_q <= 1'b0;
            s3_q[0]     <= '0;
            s3_q[1]     <= '0;
        end else if (ce) begin
            s3_valid_q  <= s2_valid_q;
            s3_last_q   <= s2_last_q;
            s3_acc_en_q <= s2_acc_en_q;
            s3_q[0]     <= re_d;
            s3_q[1]     <= im_d;
        end
    end

    // Index 0 is the real component, index 1 the imaginary one.
    logic [ACC_W-1:0] acc_q [2];
    logic [ACC_W-1:0] acc_d [2];
    logic [ACC_W-1:0] res_q [2];
    logic [1:0]       sat_hit;

    generate
        for (gi = 0; gi < 2; gi++) begin : g_sat
            logic [ACC_W:0] wide;
            assign wide        = {acc_q[gi][ACC_W-1], acc_q[gi]} + {s3_q[gi][ACC_W-1], s3_q[gi]};
            assign sat_hit[gi] = wide[ACC_W] ^ wide[ACC_W-1];
            assign acc_d[gi]   = !sat_hit[gi] ? wide[ACC_W-1:0] :
                                 wide[ACC_W]  ? {1'b1, {(ACC_W-1){1'b0}}} :
                                                {1'b0, {(ACC_W-1){1'b1}}};
        end
    endgenerate

    state_t           state_q;
    logic             sticky_q, sticky_d, out_valid_q, ovf_q;
    logic [CNT_W-1:0] cnt_q, cnt_d, beat_cnt_q;

    assign sticky_d = sticky_q | (|sat_hit);
    assign cnt_d    = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q[0]    <= '0;
            acc_q[1]    <= '0;
            res_q[0]    <= '0;
            res_q[1]    <= '0;
            sticky_q    <= 1'b0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
            beat_cnt_q  <= '0;
        end else if (ce) begin
            out_valid_q <= 1'b0;
            if (s3_valid_q) begin
                case (state_q)
                    IDLE: begin
                        if (s3_acc_en_q && !s3_last_q) begin
                            acc_q[0] <= s3_q[0];
                            acc_q[1] <= s3_q[1];
                            sticky_q <= 1'b0;
                            cnt_q    <= CNT_W'(1);
                            state_q  <= ACCUM;
                        end else begin
                            res_q[0]    <= s3_q[0];
                            res_q[1]    <= s3_q[1];
                            ovf_q       <= 1'b0;
                            beat_cnt_q  <= CNT_W'(1);
                            out_valid_q <= 1'b1;
                        end
                    end
                    ACCUM: begin
                        acc_q[0] <= acc_d[0];
                        acc_q[1] <= acc_d[1];
                        sticky_q <= sticky_d;
                        cnt_q    <= cnt_d;
                        if (s3_last_q) begin
                            res_q[0]    <= acc_d[0];
                            res_q[1]    <= acc_d[1];
                            ovf_q       <= sticky_d;
                            beat_cnt_q  <= cnt_d;
                            out_valid_q <= 1'b1;
                            state_q     <= IDLE;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign out_valid = out_valid_q;
    assign result    = {res_q[0], res_q[1]};
    assign ovf       = ovf_q;
    assign beat_cnt  = beat_cnt_q;
endmodule

// File: tb/tb_complex_mac_pipe.sv
// Bench for complex_mac_pipe: two instances (ACC_W=40 and ACC_W=34) share stimulus
// and are scored against a plain-arithmetic model, plus directed vector checks.
module tb_complex_mac_pipe;
    localparam int W   = 16;
    localparam int AW0 = 40;
    localparam int AW1 = 34;
    localparam int CW  = 16;

    logic clk = 1'b0;
    logic rst_n, ce, in_valid, in_last, acc_en;
    logic [1:0] mode;
    logic [2*W-1:0] a, b;
    logic ov0, ov1, ovf0, ovf1;
    logic [2*AW0-1:0] res0;
    logic [2*AW1-1:0] res1;
    logic [CW-1:0] cnt0, cnt1;

    always #5 clk = ~clk;

    complex_mac_pipe #(.W(W), .ACC_W(AW0), .CNT_W(CW)) dut0 (
        .clk(clk), .rst_n(rst_n), .ce(ce), .in_valid(in_valid), .in_last(in_last),
        .acc_en(acc_en), .mode(mode), .a(a), .b(b),
        .out_valid(ov0), .result(res0), .ovf(ovf0), .beat_cnt(cnt0));

    complex_mac_pipe #(.W(W), .ACC_W(AW1), .CNT_W(CW)) dut1 (
        .clk(clk), .rst_n(rst_n), .ce(ce), .in_valid(in_valid), .in_last(in_last),
        .acc_en(acc_en), .mode(mode), .a(a), .b(b),
        .out_valid(ov1), .result(res1), .ovf(ovf1), .beat_cnt(cnt1));

    typedef struct {longint re; longint im; bit ovf; int cnt; longint due;} exp_t;
    typedef struct {longint re; longint im; bit ovf; int cnt; longint at; longint cyc;} obs_t;
    typedef struct {bit [1:0] mode; int ar; int ai; int br; int bi; longint ere; longint eim;} vec_t;

    int n_cmp = 0;
    int n_bad = 0;
    longint edge_n = 0;
    longint cyc = 0;
    bit fresh = 0;
    exp_t q0[$], q1[$];
    obs_t obs0[$], obs1[$];
    longint acc_edges[$], acc_cycs[$];
    bit m_vec[2];
    longint m_re[2], m_im[2];
    bit m_sticky[2];
    int m_cnt[2];

    function automatic longint clamp(input longint v, input int aw, inout bit hit);
        longint hi = (longint'(1) << (aw - 1)) - 1;
        longint lo = -(longint'(1) << (aw - 1));
        if (v > hi) begin hit = 1; return hi; end
        if (v < lo) begin hit = 1; return lo; end
        return v;
    endfunction

    // Reference: complex arithmetic on 64-bit integers, conjugation as imaginary negation.
    task automatic model_beat(input int k);
        int aw = (k == 0) ? AW0 : AW1;
        longint ar, ai, br, bi, pre, pim;
        bit hit = 0;
        exp_t e;
        ar = longint'($signed(a[2*W-1:W]));
        ai = longint'($signed(a[W-1:0]));
        br = longint'($signed(b[2*W-1:W]));
        bi = longint'($signed(b[W-1:0]));
        if (mode == 2'b01) ai = -ai;
        else if (mode == 2'b10) bi = -bi;
        pre = ar * br - ai * bi;
        pim = ar * bi + ai * br;
        if (!m_vec[k]) begin
            if (acc_en && !in_last) begin
                m_vec[k] = 1; m_re[k] = pre; m_im[k] = pim; m_sticky[k] = 0; m_cnt[k] = 1;
                return;
            end
            e = '{pre, pim, 1'b0, 1, edge_n + 3};
        end else begin
            m_re[k] = clamp(m_re[k] + pre, aw, hit);
            m_im[k] = clamp(m_im[k] + pim, aw, hit);
            m_sticky[k] = m_sticky[k] | hit;
            if (m_cnt[k] < (1 << CW) - 1) m_cnt[k]++;
            if (!in_last) return;
            m_vec[k] = 0;
            e = '{m_re[k], m_im[k], m_sticky[k], m_cnt[k], edge_n + 3};
        end
        if (k == 0) q0.push_back(e); else q1.push_back(e);
    endtask

    always @(posedge clk) begin
        cyc++;
        fresh = 0;
        if (!rst_n) begin
            q0.delete(); q1.delete();
            m_vec[0] = 0; m_vec[1] = 0;
        end else if (ce) begin
            edge_n++;
            fresh = 1;
            if (in_valid) begin
                acc_edges.push_back(edge_n);
                acc_cycs.push_back(cyc);
                model_beat(0);
                model_beat(1);
            end
        end
    end

    task automatic check_inst(input int k);
        bit v, o, have;
        longint re, im;
        int c;
        exp_t e;
        obs_t ob;
        if (k == 0) begin
            v = ov0; o = ovf0; c = int'(cnt0);
            re = longint'($signed(res0[2*AW0-1:AW0])); im = longint'($signed(res0[AW0-1:0]));
        end else begin
            v = ov1; o = ovf1; c = int'(cnt1);
            re = longint'($signed(res1[2*AW1-1:AW1])); im = longint'($signed(res1[AW1-1:0]));
        end
        if (v) begin
            ob = '{re, im, o, c, edge_n, cyc};
            if (k == 0) obs0.push_back(ob); else obs1.push_back(ob);
            $display("tx dut%0d edge=%0d re=%0d im=%0d ovf=%0b cnt=%0d", k, edge_n, re, im, o, c);
        end
        have = 0;
        if (k == 0) begin
            if (q0.size() > 0) if (q0[0].due == edge_n) begin e = q0.pop_front(); have = 1; end
        end else begin
            if (q1.size() > 0) if (q1[0].due == edge_n) begin e = q1.pop_front(); have = 1; end
        end
        if (have) begin
            n_cmp++;
            if (!v || re != e.re || im != e.im || o != e.ovf || c != e.cnt) begin
                n_bad++;
                $display("FAIL sb_dut%0d edge=%0d: got v=%0b re=%0d im=%0d ovf=%0b cnt=%0d, expected v=1 re=%0d im=%0d ovf=%0b cnt=%0d",
                         k, edge_n, v, re, im, o, c, e.re, e.im, e.ovf, e.cnt);
            end
        end else if (v) begin
            n_cmp++;
            n_bad++;
            $display("FAIL sb_dut%0d edge=%0d: unexpected out_valid re=%0d im=%0d, expected none", k, edge_n, re, im);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && fresh) begin
            check_inst(0);
            check_inst(1);
        end
    end

    task automatic chk_zero(input string nm);
        n_cmp++;
        if (ov0 !== 1'b0 || ovf0 !== 1'b0 || res0 !== '0 || cnt0 !== '0 ||
            ov1 !== 1'b0 || ovf1 !== 1'b0 || res1 !== '0 || cnt1 !== '0) begin
            n_bad++;
            $display("FAIL %s: got v=%b/%b ovf=%b/%b res=%h/%h cnt=%h/%h, expected all zero",
                     nm, ov0, ov1, ovf0, ovf1, res0, res1, cnt0, cnt1);
        end
    endtask

    task automatic chk_obs(input string nm, input obs_t ob, input longint re, input longint im,
                           input bit o, input int c);
        n_cmp++;
        if (ob.re != re || ob.im != im || ob.ovf != o || ob.cnt != c) begin
            n_bad++;
            $display("FAIL %s: got re=%0d im=%0d ovf=%0b cnt=%0d, expected re=%0d im=%0d ovf=%0b cnt=%0d",
                     nm, ob.re, ob.im, ob.ovf, ob.cnt, re, im, o, c);
        end
    endtask

    task automatic chk_int(input string nm, input longint got, input longint want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, got, want);
        end
    endtask

    task automatic put(input int m, input int ar, input int ai, input int br, input int bi,
                       input bit en, input bit last);
        mode = 2'(m); a = {16'(ar), 16'(ai)}; b = {16'(br), 16'(bi)};
        acc_en = en; in_last = last; in_valid = 1'b1;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0; acc_en = 1'b0; in_last = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [15:0] rnd16();
        case ($urandom % 4)
            0: return 16'h8000;
            1: return 16'h7fff;
            default: return 16'($urandom);
        endcase
    endfunction

    vec_t tbl[6];

    initial begin
        tbl[0] = '{2'b00, 3, 4, 1, 2, -5, 10};
        tbl[1] = '{2'b01, 3, 4, 1, 2, 11, 2};
        tbl[2] = '{2'b10, 3, 4, 1, 2, 11, -2};
        tbl[3] = '{2'b11, 3, 4, 1, 2, -5, 10};
        tbl[4] = '{2'b01, -32768, -32768, -32768, -32768, 64'sd2147483648, 0};
        tbl[5] = '{2'b00, -32768, -32768, -32768, -32768, 0, 64'sd2147483648};

        rst_n = 1'b0; ce = 1'b1; in_valid = 1'b0; in_last = 1'b0; acc_en = 1'b0;
        mode = 2'b00; a = '0; b = '0;
        repeat (3) @(negedge clk);
        chk_zero("reset_state");
        rst_n = 1'b1;
        @(negedge clk);

        // Plain products across all modes plus the most-negative operands.
        obs0.delete(); acc_edges.delete();
        for (int i = 0; i < 6; i++)
            put(tbl[i].mode, tbl[i].ar, tbl[i].ai, tbl[i].br, tbl[i].bi, 1'b0, 1'b0);
        idle(8);
        chk_int("table_count", obs0.size(), 6);
        for (int i = 0; i < 6; i++) begin
            if (i < obs0.size() && i < acc_edges.size()) begin
                chk_obs($sformatf("table_%0d", i), obs0[i], tbl[i].ere, tbl[i].eim, 1'b0, 1);
                chk_int($sformatf("table_latency_%0d", i), obs0[i].at - acc_edges[i], 3);
            end
        end

        // Three-cycle ce stall in the middle of the first stream.
        obs0.delete(); acc_cycs.delete();
        put(0, 3, 4, 1, 2, 1'b0, 1'b0);
        put(1, 3, 4, 1, 2, 1'b0, 1'b0);
        mode = 2'b10; ce = 1'b0;
        repeat (3) @(negedge clk);
        ce = 1'b1;
        @(negedge clk);
        put(3, 3, 4, 1, 2, 1'b0, 1'b0);
        idle(10);
        chk_int("stall_count", obs0.size(), 4);
        for (int i = 0; i < 4; i++)
            if (i < obs0.size()) chk_obs($sformatf("stall_%0d", i), obs0[i], tbl[i].ere, tbl[i].eim, 1'b0, 1);
        if (obs0.size() == 4 && acc_cycs.size() > 0)
            chk_int("stall_span", obs0[3].cyc - acc_cycs[0], 9);

        // Four-beat conj(A) norm of (1,1).
        obs0.delete(); acc_edges.delete();
        put(1, 1, 1, 1, 1, 1'b1, 1'b0);
        put(1, 1, 1, 1, 1, 1'b0, 1'b0);
        put(1, 1, 1, 1, 1, 1'b1, 1'b0);
        put(1, 1, 1, 1, 1, 1'b0, 1'b1);
        idle(8);
        chk_int("accum_count", obs0.size(), 1);
        if (obs0.size() > 0) begin
            chk_obs("accum_result", obs0[0], 8, 0, 1'b0, 4);
            if (acc_edges.size() == 4) chk_int("accum_latency", obs0[0].at - acc_edges[3], 3);
        end

        // Saturation on the narrow accumulator, then a clean plain beat.
        obs0.delete(); obs1.delete();
        put(1, -32768, -32768, -32768, -32768, 1'b1, 1'b0);
        repeat (3) put(1, -32768, -32768, -32768, -32768, 1'b0, 1'b0);
        put(1, -32768, -32768, -32768, -32768, 1'b0, 1'b1);
        put(0, 3, 4, 1, 2, 1'b0, 1'b0);
        idle(8);
        chk_int("sat_count", obs1.size(), 2);
        if (obs1.size() == 2) begin
            chk_obs("sat_result", obs1[0], 64'sd8589934591, 0, 1'b1, 5);
            chk_obs("sat_after", obs1[1], -5, 10, 1'b0, 1);
        end
        if (obs0.size() > 0) chk_obs("wide_no_sat", obs0[0], 64'sd10737418240, 0, 1'b0, 5);

        // Reset in the middle of a vector, then a fresh plain beat.
        put(0, 3, 4, 1, 2, 1'b1, 1'b0);
        put(0, 3, 4, 1, 2, 1'b0, 1'b0);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_zero("reset_mid_vector");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        obs0.delete();
        put(0, 3, 4, 1, 2, 1'b0, 1'b1);
        idle(8);
        chk_int("post_reset_count", obs0.size(), 1);
        if (obs0.size() > 0) chk_obs("post_reset", obs0[0], -5, 10, 1'b0, 1);

        // Random traffic with stalls, scored by the model.
        for (int i = 0; i < 600; i++) begin
            ce       = ($urandom % 8) != 0;
            in_valid = ($urandom % 5) != 0;
            mode     = 2'($urandom);
            acc_en   = ($urandom % 2) != 0;
            in_last  = ($urandom % 4) == 0;
            a        = {rnd16(), rnd16()};
            b        = {rnd16(), rnd16()};
            @(negedge clk);
        end
        ce = 1'b1;
        idle(10);
        chk_int("leftover_expected", q0.size() + q1.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/complex_mac_pipe.md
Name: complex_mac_pipe

Overview:
- Parametrised, pipelined fixed-point complex multiplier; next generation of the single-mode conjugate multiplier.
- Per-beat conjugation mode: none, conj(A) or conj(B).
- Optional vector accumulation: complex dot product / norm for the iterative solver datapath.
- Exact full-precision products, saturating accumulator, valid/last stream interface with `ce` stall.

Parameters:
- W, 16, width of each real/imag component of A and B (signed two's complement).
- ACC_W, 40, width of each result component; must be >= 2W+1.
- CNT_W, 16, width of the beat counter reported with each result.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- ce  in  1  clock enable; 0 freezes every register including valids and FSM.
- in_valid  in  1  input beat valid.
- in_last  in  1  last beat of an accumulated vector; ignored when not accumulating.
- acc_en  in  1  start an accumulated vector; sampled only on the first beat of a vector.
- mode  in  2  00 plain A*B, 01 conj(A)*B, 10 A*conj(B), 11 treated as 00; sampled per beat.
- a  in  2W  {a_re[2W-1:W], a_im[W-1:0]}.
- b  in  2W  {b_re, b_im}, same packing as `a`.
- out_valid  out  1  result valid, one cycle per result.
- result  out  2*ACC_W  {re, im}, real part in the upper half.
- ovf  out  1  a component saturated during this result.
- beat_cnt  out  CNT_W  beats contributing to this result; saturates at all-ones.

Behaviour:
- Reset (async, rst_n=0): out_valid=0, result=0, ovf=0, beat_cnt=0, all stage valids 0, FSM=IDLE, accumulator 0.
- Products are exact; conjugation is applied by sign selection, never by negating an input, so -2^(W-1) is safe:
  - plain: re=ar*br-ai*bi, im=ar*bi+ai*br
  - conjA: re=ar*br+ai*bi, im=ar*bi-ai*br
  - conjB: re=ar*br+ai*bi, im=ai*br-ar*bi
  - Terms are 2W bits; sums are 2W+1 bits, sign-extended to ACC_W.
- Pipeline (all stages advance only when ce=1):
  - S1 registers inputs and control.
  - S2 registers the four products.
  - S3 registers the sums.
  - S4 is the output/accumulator register.
  - Latency: 4 ce-cycles from an accepted beat to out_valid. Throughput: 1 beat/cycle, no backpressure.
- FSM at S4, states IDLE and ACCUM:
  - IDLE, beat with acc_en=0: result=product, ovf=0, beat_cnt=1, out_valid=1; stay IDLE.
  - IDLE, beat with acc_en=1, in_last=0: acc=product, ovf sticky cleared, cnt=1, out_valid=0; go to ACCUM.
  - IDLE, beat with acc_en=1, in_last=1: single-beat vector, same as the acc_en=0 case; stay IDLE.
  - ACCUM, any beat: acc+=product with per-component saturation to [-2^(ACC_W-1), 2^(ACC_W-1)-1]; ovf sticky |= saturation event; cnt+=1 (saturating). acc_en is ignored.
  - ACCUM, beat with in_last=1: result=updated acc, ovf=sticky, beat_cnt=cnt, out_valid=1; go to IDLE.
  - Once saturated, a component stays clamped unless later products move it back in range; the sticky flag remains set.
  - No beat: out_valid=0; result, ovf and beat_cnt hold their last values.
- ce=0 mid-vector: state, accumulator and count hold; out_valid holds its value but must be qualified by ce downstream.
- Reset mid-vector: the partial sum is discarded; the next beat starts fresh in IDLE.

Test Plan:
- W=16, a=(3,4), b=(1,2), acc_en=0, modes 00/01/10/11 on consecutive cycles -> results (-5,10), (11,2), (11,-2), (-5,10); out_valid 4 cycles after each beat; beat_cnt=1; ovf=0.
- a=b=(-32768,-32768): mode 01 -> (2147483648, 0); mode 00 -> (0, 2147483648); no ovf at ACC_W=40.
- Accumulated vector of 4 beats, mode 01, a=b=(1,1), acc_en=1 on beat 1, in_last on beat 4 -> single out_valid 4 cycles after beat 4; result (8,0); beat_cnt=4. No out_valid for beats 1-3.
- ACC_W=34, 5-beat vector of mode 01 with a=b=(-32768,-32768) -> re saturates to 8589934591; im=0; ovf=1. Next plain beat reports ovf=0.
- ce stall: ce low for 3 cycles mid-stream of the first test -> results and order unchanged, shifted by 3 cycles, no duplicated or lost out_valid.
- rst_n pulsed low after beat 2 of a 4-beat vector -> outputs immediately 0. A new plain beat (3,4)*(1,2) after release -> (-5,10), beat_cnt=1.
